mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 25 ++
 rtl/mem_wb_stage_load_ext.sv | 28 ++
 rtl/mem_wb_stage.sv | 108 ++++++++++
 tb/tb_mem_wb_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Constants and types shared by the MEM and WB pipeline stages.
// Covers access-size codes, load-extension widths and the WB bubble value.
package mem_wb_stage_pkg;

  // Access-size codes driven by the MEM stage; both 10 and 11 mean a full word.
  typedef enum logic [1:0] {
    BHW_BYTE     = 2'b00,
    BHW_HALF     = 2'b01,
    BHW_WORD     = 2'b10,
    BHW_WORD_ALT = 2'b11
  } bhw_e;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned HALF_W       = 16;
  localparam int unsigned INST_COUNT_W = 32;

  typedef struct packed {
    logic valid;
    logic reg_write;
  } wb_ctrl_t;

  // A bubble retires nothing and writes nothing; data and address fields are cleared as well.
  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Sign/zero extension of a data-memory read according to the access size.
module load_ext
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] data,
  input  logic [1:0]   bhw,
  input  logic         is_unsigned,
  output logic [W-1:0] ext_data
);

  logic byte_fill;
  logic half_fill;

  assign byte_fill = ~is_unsigned & data[BYTE_W-1];
  assign half_fill = ~is_unsigned & data[HALF_W-1];

  always_comb begin
    ext_data = data;
    case (bhw_e'(bhw))
      BHW_BYTE: ext_data = {{(W - BYTE_W){byte_fill}}, data[BYTE_W-1:0]};
      BHW_HALF: ext_data = {{(W - HALF_W){half_fill}}, data[HALF_W-1:0]};
      default:  ext_data = data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extension, write-back select, retire counter and sticky halt.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned INST_SZ = 32,
  parameter int unsigned REG_SZ  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_flush,
  input  logic                    i_valid_M,
  input  logic [INST_SZ-1:0]      i_alu_result_M,
  input  logic [INST_SZ-1:0]      i_read_data_M,
  input  logic [INST_SZ-1:0]      i_pc8_M,
  input  logic                    i_reg_write_M,
  input  logic                    i_mem_to_reg_M,
  input  logic                    i_link_M,
  input  logic                    i_unsigned_M,
  input  logic                    i_halt_M,
  input  logic [1:0]              i_bhw_M,
  input  logic [REG_SZ-1:0]       i_write_reg_M,
  output logic [INST_SZ-1:0]      o_write_data_W,
  output logic [REG_SZ-1:0]       o_write_reg_W,
  output logic                    o_reg_write_W,
  output logic                    o_valid_W,
  output logic                    o_halt_W,
  output logic [INST_COUNT_W-1:0] o_inst_count
);

  logic [INST_SZ-1:0]      ext_data;
  logic [INST_SZ-1:0]      sel_data;

  logic [INST_SZ-1:0]      write_data_q, write_data_d;
  logic [REG_SZ-1:0]       write_reg_q, write_reg_d;
  wb_ctrl_t                ctrl_q, ctrl_d;
  logic                    halt_q, halt_d;
  logic [INST_COUNT_W-1:0] count_q, count_d;

  logic                    retire;

  load_ext #(
    .W (INST_SZ)
  ) u_load_ext (
    .data        (i_read_data_M),
    .bhw         (i_bhw_M),
    .is_unsigned (i_unsigned_M),
    .ext_data    (ext_data)
  );

  always_comb begin
    sel_data = i_alu_result_M;
    if (i_link_M) begin
      sel_data = i_pc8_M;
    end else if (i_mem_to_reg_M) begin
      sel_data = ext_data;
    end
  end

  // Once halted, captures are turned into bubbles so the debugger sees a frozen machine.
  assign retire = i_enable & ~i_flush & ~halt_q & i_valid_M;

  always_comb begin
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    ctrl_d       = ctrl_q;
    halt_d       = halt_q;
    count_d      = count_q;
    if (i_flush || (i_enable && halt_q)) begin
      write_data_d = '0;
      write_reg_d  = '0;
      ctrl_d       = WB_CTRL_BUBBLE;
    end else if (i_enable) begin
      write_data_d     = sel_data;
      write_reg_d      = i_write_reg_M;
      ctrl_d.valid     = i_valid_M;
      ctrl_d.reg_write = i_valid_M & i_reg_write_M & (i_write_reg_M != '0);
    end
    if (retire) begin
      count_d = count_q + INST_COUNT_W'(1);
      halt_d  = i_halt_M;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      write_data_q <= '0;
      write_reg_q  <= '0;
      ctrl_q       <= WB_CTRL_BUBBLE;
      halt_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      ctrl_q       <= ctrl_d;
      halt_q       <= halt_d;
      count_q      <= count_d;
    end
  end

  assign o_write_data_W = write_data_q;
  assign o_write_reg_W  = write_reg_q;
  assign o_reg_write_W  = ctrl_q.reg_write;
  assign o_valid_W      = ctrl_q.valid;
  assign o_halt_W       = halt_q;
  assign o_inst_count   = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        valid_m;
  logic [31:0] alu_m;
  logic [31:0] rdata_m;
  logic [31:0] pc8_m;
  logic        reg_write_m;
  logic        mem_to_reg_m;
  logic        link_m;
  logic        unsigned_m;
  logic        halt_m;
  logic [1:0]  bhw_m;
  logic [4:0]  wreg_m;
  logic [31:0] wdata_w;
  logic [4:0]  wreg_w;
  logic        reg_write_w;
  logic        valid_w;
  logic        halt_w;
  logic [31:0] count;

  int vectors = 0;
  int miscompares = 0;

  mem_wb_stage #(
    .INST_SZ (32),
    .REG_SZ  (5)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (enable),
    .i_flush        (flush),
    .i_valid_M      (valid_m),
    .i_alu_result_M (alu_m),
    .i_read_data_M  (rdata_m),
    .i_pc8_M        (pc8_m),
    .i_reg_write_M  (reg_write_m),
    .i_mem_to_reg_M (mem_to_reg_m),
    .i_link_M       (link_m),
    .i_unsigned_M   (unsigned_m),
    .i_halt_M       (halt_m),
    .i_bhw_M        (bhw_m),
    .i_write_reg_M  (wreg_m),
    .o_write_data_W (wdata_w),
    .o_write_reg_W  (wreg_w),
    .o_reg_write_W  (reg_write_w),
    .o_valid_W      (valid_w),
    .o_halt_W       (halt_w),
    .o_inst_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inst(input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc8,
                      input logic rw, input logic m2r, input logic lnk, input logic uns,
                      input logic [1:0] bhw, input logic [4:0] wr);
    valid_m      = 1'b1;
    alu_m        = alu;
    rdata_m      = rd;
    pc8_m        = pc8;
    reg_write_m  = rw;
    mem_to_reg_m = m2r;
    link_m       = lnk;
    unsigned_m   = uns;
    bhw_m        = bhw;
    wreg_m       = wr;
    halt_m       = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d, input logic [4:0] r,
                         input logic rw, input logic v, input logic h, input logic [31:0] c);
    chk({tag, ".data"}, wdata_w, d);
    chk({tag, ".reg"}, {27'd0, wreg_w}, {27'd0, r});
    chk({tag, ".rw"}, {31'd0, reg_write_w}, {31'd0, rw});
    chk({tag, ".valid"}, {31'd0, valid_w}, {31'd0, v});
    chk({tag, ".halt"}, {31'd0, halt_w}, {31'd0, h});
    chk({tag, ".count"}, count, c);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    inst(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 5'd0);
    valid_m = 1'b0;
    #2;
    chk_all("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    #5;
    rst = 1'b0;
    tick();

    enable = 1'b1;
    inst(32'h0, 32'h000000F0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd8);
    tick();
    chk_all("lb_signed", 32'hFFFFFFF0, 5'd8, 1'b1, 1'b1, 1'b0, 32'd1);

    inst(32'h0, 32'h0000F0F0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 5'd9);
    tick();
    chk("lhu.data", wdata_w, 32'h0000F0F0);
    chk("lhu.count", count, 32'd2);

    inst(32'h0, 32'h12348001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd9);
    tick();
    chk("lh_signed.data", wdata_w, 32'hFFFF8001);

    inst(32'h0, 32'hABCD0080, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd10);
    tick();
    chk("lbu.data", wdata_w, 32'h00000080);

    inst(32'h0, 32'h87654321, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 5'd11);
    tick();
    chk("lw.data", wdata_w, 32'h87654321);

    inst(32'h12345678, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd12);
    tick();
    chk_all("alu", 32'h12345678, 5'd12, 1'b1, 1'b1, 1'b0, 32'd6);

    inst(32'h11111111, 32'h22222222, 32'h00000024, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 5'd0);
    tick();
    chk_all("link_r0", 32'h00000024, 5'd0, 1'b0, 1'b1, 1'b0, 32'd7);

    enable = 1'b0;
    inst(32'h0000DEAD, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 32'h00000024, 5'd0, 1'b0, 1'b1, 1'b0, 32'd7);
    end

    flush = 1'b1;
    tick();
    chk_all("flush_noen", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd7);
    flush = 1'b0;

    enable = 1'b1;
    valid_m = 1'b0;
    tick();
    chk("invalid.valid", {31'd0, valid_w}, 32'd0);
    chk("invalid.rw", {31'd0, reg_write_w}, 32'd0);
    chk("invalid.count", count, 32'd7);

    valid_m = 1'b1;
    tick();
    chk_all("pre_reset", 32'h0000DEAD, 5'd3, 1'b1, 1'b1, 1'b0, 32'd8);

    // Asynchronous reset between edges.
    rst = 1'b1;
    #1;
    chk_all("async_reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    chk_all("post_reset", 32'h0000DEAD, 5'd3, 1'b1, 1'b1, 1'b0, 32'd1);

    force dut.count_q = 32'hFFFFFFFF;
    #1;
    release dut.count_q;
    #1;
    chk("preload", count, 32'hFFFFFFFF);
    tick();
    chk("wrap", count, 32'd0);

    flush = 1'b1;
    halt_m = 1'b1;
    tick();
    chk_all("flush_halt", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    flush = 1'b0;

    tick();
    chk_all("halt", 32'h0000DEAD, 5'd3, 1'b1, 1'b1, 1'b1, 32'd1);

    halt_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("halted", 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1);
    end

    flush = 1'b1;
    tick();
    chk("halted_flush.halt", {31'd0, halt_w}, 32'd1);
    flush = 1'b0;

    rst = 1'b1;
    #1;
    chk_all("final_reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
